// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-point adder between two requesters.
// Sum is quantised to S(11.10) by wrap+truncate or saturate+round.
module fp_add_arbiter #(
    parameter int NB_IN_A  = 16,
    parameter int NBF_IN_A = 14,
    parameter int NB_IN_B  = 12,
    parameter int NBF_IN_B = 11,
    parameter int NB_OUT   = 11,
    parameter int NBF_OUT  = 10
) (
    input  logic                clock,
    input  logic                i_rst_n,
    input  logic [1:0]          i_valid,
    input  logic [NB_IN_A-1:0]  i_A0,
    input  logic [NB_IN_B-1:0]  i_B0,
    input  logic                i_mode0,
    input  logic [NB_IN_A-1:0]  i_A1,
    input  logic [NB_IN_B-1:0]  i_B1,
    input  logic                i_mode1,
    output logic [1:0]          o_ready,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_OUT-1:0]   o_sum,
    output logic                o_id,
    output logic                o_ovf
);

    localparam int NBI_A  = NB_IN_A - NBF_IN_A;
    localparam int NBI_B  = NB_IN_B - NBF_IN_B;
    localparam int NBI_FR = ((NBI_A > NBI_B) ? NBI_A : NBI_B) + 1;
    localparam int NBF_FR = (NBF_IN_A > NBF_IN_B) ? NBF_IN_A : NBF_IN_B;
    localparam int NB_FR  = NBI_FR + NBF_FR;
    localparam int NB_R   = NB_FR + 1;
    localparam int SH_A   = NBF_FR - NBF_IN_A;
    localparam int SH_B   = NBF_FR - NBF_IN_B;
    localparam int LSB    = NBF_FR - NBF_OUT;
    localparam int MSB    = LSB + NB_OUT - 1;
    localparam int HALF   = 1 << (LSB - 1);

    localparam logic [NB_OUT-1:0] SAT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
    localparam logic [NB_OUT-1:0] SAT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t state_q, state_d;
    logic [1:0]         grant;
    logic               ptr_q;
    logic [NB_IN_A-1:0] a_q;
    logic [NB_IN_B-1:0] b_q;
    logic               mode_q;
    logic               id_q;

    logic signed [NB_FR-1:0] a_al, b_al, sum;
    logic signed [NB_R-1:0]  rnd;
    logic [NB_OUT-1:0]       q_sum;
    logic                    q_ovf;
    logic                    unused_rnd_lsb;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: accept, one compute cycle, hold until drained
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|o_ready) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: round-robin grant, offered only in IDLE
    always_comb begin
        grant = 2'b00;
        unique case (i_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        o_ready = (state_q == IDLE) ? grant : 2'b00;
    end

    // Capture the granted requester's operands and move the pointer
    always_ff @(posedge clock) begin
        if (!i_rst_n) begin
            ptr_q  <= 1'b1;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            id_q   <= 1'b0;
        end else if (|o_ready) begin
            ptr_q  <= o_ready[1];
            id_q   <= o_ready[1];
            a_q    <= o_ready[1] ? i_A1 : i_A0;
            b_q    <= o_ready[1] ? i_B1 : i_B0;
            mode_q <= o_ready[1] ? i_mode1 : i_mode0;
        end
    end

    // Align, add at full resolution, then quantise per mode
    always_comb begin
        a_al = NB_FR'($signed(a_q)) <<< SH_A;
        b_al = NB_FR'($signed(b_q)) <<< SH_B;
        sum  = a_al + b_al;
        rnd  = NB_R'(sum) + NB_R'(HALF);
        if (!mode_q) begin
            q_sum = sum[MSB:LSB];
            q_ovf = !((&sum[NB_FR-1:MSB]) || (~|sum[NB_FR-1:MSB]));
        end else if ((&rnd[NB_R-1:MSB]) || (~|rnd[NB_R-1:MSB])) begin
            q_sum = rnd[MSB:LSB];
            q_ovf = 1'b0;
        end else begin
            q_sum = rnd[NB_R-1] ? SAT_MIN : SAT_MAX;
            q_ovf = 1'b1;
        end
    end

    assign unused_rnd_lsb = ^rnd[LSB-1:0];

    // Result register: load in CALC, hold until downstream takes it
    always_ff @(posedge clock) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_id    <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (state_q == CALC) begin
            o_valid <= 1'b1;
            o_sum   <= q_sum;
            o_id    <= id_q;
            o_ovf   <= q_ovf;
        end else if (state_q == OUT && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: transaction-level model of
// arbitration and quantisation, compared every cycle.
module tb_fp_add_arbiter;

    logic        clock = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_valid;
    logic [15:0] i_A0, i_A1;
    logic [11:0] i_B0, i_B1;
    logic        i_mode0, i_mode1;
    logic [1:0]  o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [10:0] o_sum;
    logic        o_id;
    logic        o_ovf;

    typedef struct packed {
        logic [10:0] sum;
        logic        id;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    int   acc_log[$];
    int   checks = 0;
    int   errors = 0;
    int   m_phase;
    int   m_ptr;

    fp_add_arbiter dut (
        .clock   (clock),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_A0    (i_A0),
        .i_B0    (i_B0),
        .i_mode0 (i_mode0),
        .i_A1    (i_A1),
        .i_B1    (i_B1),
        .i_mode1 (i_mode1),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_id    (o_id),
        .o_ovf   (o_ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a,
                                   input logic [11:0] b,
                                   input logic m, input logic id);
        exp_t e;
        int   s, q;
        s = int'($signed(a)) + int'($signed(b)) * 8;
        e.ovf = 1'b0;
        if (!m) begin
            q = s >>> 4;
            e.ovf = (s < -16384) || (s > 16383);
        end else begin
            q = (s + 8) >>> 4;
            if (q > 1023) begin
                q = 1023;
                e.ovf = 1'b1;
            end else if (q < -1024) begin
                q = -1024;
                e.ovf = 1'b1;
            end
        end
        e.sum = q[10:0];
        e.id  = id;
        return e;
    endfunction

    // One clock: check DUT against model using current inputs, advance
    task automatic cyc();
        logic [1:0] g;
        int         k;
        #1;
        g = 2'b00;
        if (m_phase == 0) begin
            if (i_valid == 2'b01)      g = 2'b01;
            else if (i_valid == 2'b10) g = 2'b10;
            else if (i_valid == 2'b11) g = (m_ptr == 1) ? 2'b01 : 2'b10;
        end
        chk("ready", o_ready, g);
        chk("valid", o_valid, m_phase == 2);
        if (m_phase == 2) begin
            if (sbq.size() == 0) begin
                chk("sb_depth", 0, 1);
            end else begin
                chk("sum", o_sum, sbq[0].sum);
                chk("id",  o_id,  sbq[0].id);
                chk("ovf", o_ovf, sbq[0].ovf);
                if (i_ready && i_rst_n) void'(sbq.pop_front());
            end
        end
        if (!i_rst_n) begin
            m_phase = 0;
            m_ptr   = 1;
            sbq.delete();
        end else begin
            case (m_phase)
                0: if (g != 2'b00) begin
                    k = g[1] ? 1 : 0;
                    if (k == 1) sbq.push_back(model(i_A1, i_B1, i_mode1, 1'b1));
                    else        sbq.push_back(model(i_A0, i_B0, i_mode0, 1'b0));
                    acc_log.push_back(k);
                    m_ptr   = k;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (i_ready) m_phase = 0;
            endcase
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 2'b00;
        i_ready = 1'b1;
        cyc();
        cyc();
        i_rst_n = 1'b1;
    endtask

    // Single request from requester k, then drain back to IDLE
    task automatic send(input int k, input logic [15:0] a,
                        input logic [11:0] b, input logic m);
        if (k == 1) begin
            i_A1 = a; i_B1 = b; i_mode1 = m; i_valid = 2'b10;
        end else begin
            i_A0 = a; i_B0 = b; i_mode0 = m; i_valid = 2'b01;
        end
        cyc();
        i_valid = 2'b00;
        for (int i = 0; i < 10 && (m_phase != 0 || sbq.size() != 0); i++)
            cyc();
        chk("drained", sbq.size(), 0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 2'b00;
        i_ready = 1'b1;
        i_A0 = '0; i_B0 = '0; i_mode0 = 1'b0;
        i_A1 = '0; i_B1 = '0; i_mode1 = 1'b0;
        m_phase = 0;
        m_ptr   = 1;
        repeat (2) @(negedge clock);
        i_rst_n = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_sum",   o_sum,   0);
        chk("rst_id",    o_id,    0);
        chk("rst_ovf",   o_ovf,   0);
        chk("rst_ready", o_ready, 0);
        @(negedge clock);

        send(0, 16'h1000, 12'h100, 1'b0);
        send(0, 16'h4000, 12'h400, 1'b0);
        send(0, 16'h4000, 12'h400, 1'b1);
        send(1, 16'hC000, 12'hC00, 1'b0);
        send(1, 16'hC000, 12'hC00, 1'b1);
        send(0, 16'h0008, 12'h000, 1'b0);
        send(0, 16'h0008, 12'h000, 1'b1);
        send(1, 16'h7FFF, 12'h7FF, 1'b1);
        send(0, 16'h8000, 12'h800, 1'b1);

        do_reset();
        acc_log.delete();
        i_A0 = 16'h0123; i_B0 = 12'h045; i_mode0 = 1'b0;
        i_A1 = 16'hF000; i_B1 = 12'h7F0; i_mode1 = 1'b1;
        i_valid = 2'b11;
        run(12);
        i_valid = 2'b00;
        run(4);
        chk("rr_count", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size(); i++)
            chk("rr_order", acc_log[i], i % 2);

        i_ready = 1'b0;
        send_stall: begin
            i_A1 = 16'h2000; i_B1 = 12'h300; i_mode1 = 1'b1;
            i_valid = 2'b10;
            cyc();
            i_valid = 2'b11;
            run(6);
            i_rst_n = 1'b0;
            cyc();
            i_rst_n = 1'b1;
            i_valid = 2'b00;
            #1;
            chk("mid_rst_valid", o_valid, 0);
            chk("mid_rst_sum",   o_sum,   0);
            @(negedge clock);
        end
        i_ready = 1'b1;
        acc_log.delete();
        i_A0 = 16'h0800; i_B0 = 12'h080; i_mode0 = 1'b1;
        i_valid = 2'b11;
        cyc();
        i_valid = 2'b00;
        run(4);
        chk("post_rst_grant", acc_log.size() > 0 ? acc_log[0] : 9, 0);

        for (int i = 0; i < 150; i++) begin
            i_valid = 2'($urandom_range(0, 3));
            i_A0 = 16'($urandom); i_B0 = 12'($urandom);
            i_A1 = 16'($urandom); i_B1 = 12'($urandom);
            i_mode0 = 1'($urandom); i_mode1 = 1'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        i_valid = 2'b00;
        i_ready = 1'b1;
        run(5);
        chk("final_drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
